sl_pipe_shifter: RTL
====================

SL_PIPE_SHIFTER -- requirements
Module: sl_pipe_shifter

Interface
REQ-001 Parameters: none; WIDTH=64 and SHW=6 SHALL come from shifter_pkg.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_data  input  64  operand.
REQ-007 in_shamt  input  6  shift amount, 0..63.
REQ-008 in_op  input  1  shift_op_e: SL_LOGICAL=0 (zero-fill), SL_ROTATE=1 (rotate left).
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  64  shifted result.
REQ-012 out_ovf  output  1  high when any 1-bit was shifted out in SL_LOGICAL mode; always 0 in SL_ROTATE mode.

Function
REQ-013 Transfer: a transfer SHALL occur on each edge where valid and ready are both high; in_data, in_shamt and in_op SHALL be sampled only on such edges.
REQ-014 Datapath: six cascaded left stages of weight 1, 2, 4, 8, 16, 32, each gated by shamt bit 0..5 respectively.
REQ-015 Pipeline register R1 SHALL follow stages 0-1, R2 follow stages 2-3, and R3 follow stages 4-5; R3 SHALL drive out_data, out_ovf and out_valid directly.
REQ-016 Each Rn SHALL carry: valid, data, the still-unused shamt bits, op, and the accumulated ovf.
REQ-017 Latency: a request accepted in cycle t SHALL be presented on out_* in cycle t+3 when no stall occurs.
REQ-018 Throughput: one request per cycle when out_ready is held high.
REQ-019 Elastic control: ready3 = !v3 || out_ready; ready2 = !v2 || ready3; ready1 = !v1 || ready2; in_ready = ready1 (combinational path from out_ready is permitted).
REQ-020 A stage register SHALL load when its upstream holds valid and it is ready; otherwise it SHALL clear its valid when drained, or hold when stalled. Bubbles SHALL collapse.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_ovf SHALL remain stable.
REQ-022 Result order SHALL equal acceptance order; no request SHALL be dropped or duplicated.
REQ-023 SL_LOGICAL: out_data = in_data << in_shamt, zero-filled; out_ovf = OR of the in_shamt MSBs of in_data that were shifted out.
REQ-024 SL_ROTATE: out_data = rotate-left(in_data, in_shamt); out_ovf = 0.
REQ-025 in_shamt=0 SHALL pass the data unchanged with out_ovf=0.
REQ-026 Full condition: with v1=v2=v3=1 and out_ready=0, in_ready SHALL be 0.
REQ-027 Simultaneous accept and output: a new input SHALL be accepted in the same cycle R3 drains.

Reset
REQ-028 While rst=1, all valid bits SHALL clear, so out_valid=0; in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-029 Reset SHALL apply even in the middle of an operation; in-flight requests SHALL be discarded, with no partial output afterwards.
REQ-030 The data, shamt and ovf fields of the pipeline registers do not need a reset.
REQ-031 The output values out_data=0 and out_ovf=0 SHALL hold while out_valid=0 after reset.

Structure
REQ-032 shifter_pkg SHALL hold WIDTH, SHW, shift_op_e, and a packed stage-record typedef {data, shamt, op, ovf}.
REQ-033 Sub-module stage_sl #(SHAMT) SHALL implement one combinational stage: it shifts or rotates left by SHAMT when its sel input is high and ORs the lost bits into ovf. There SHALL be six instances.
REQ-034 The module SHALL contain no other sub-modules and no latches.

Verification
REQ-035 LOGICAL, in_data=0x0000_0000_0000_0001, shamt=63 -> out_data=0x8000_0000_0000_0000, out_ovf=0, valid in cycle t+3.
REQ-036 LOGICAL, in_data=0xFFFF_FFFF_FFFF_FFFF, shamt=4 -> out_data=0xFFFF_FFFF_FFFF_FFF0, out_ovf=1. ROTATE on the same input -> unchanged, out_ovf=0.
REQ-037 ROTATE, in_data=0x8000_0000_0000_0001, shamt=1 -> 0x0000_0000_0000_0003; shamt=0 on any input -> passthrough.
REQ-038 Backpressure: out_ready=0, issue 5 back-to-back requests -> exactly 3 accepted and in_ready=0. Raise out_ready -> the results appear in order, 1 per cycle, and the remaining 2 are then accepted.
REQ-039 Reset mid-flight: 3 requests in flight, then assert rst for 1 cycle -> out_valid=0 for the following cycles and none of the 3 results ever appears.
REQ-040 Random throughput: 10k random ops with random out_ready, checked against a reference model -> zero mismatches and order preserved.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared widths, operation encoding and the per-stage record carried down the
// shifter pipeline.
package shifter_pkg;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned SHW   = 6;

    typedef enum logic {
        SL_LOGICAL = 1'b0,
        SL_ROTATE  = 1'b1
    } shift_op_e;

    // Payload passed between shift stages and held in each pipeline register
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   shamt;
        shift_op_e        op;
        logic             ovf;
    } stage_rec_t;

endpackage

// File: rtl/stage_sl.sv
// One combinational left-shift/rotate stage of fixed weight SHAMT, enabled by sel.
// Bits pushed out of the top are folded into ovf for logical shifts only.
module stage_sl
    import shifter_pkg::*;
#(
    parameter int unsigned SHAMT = 1
) (
    input  logic       sel,
    input  stage_rec_t rec_in,
    output stage_rec_t rec_out
);

    logic [SHAMT-1:0] lost;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] rotated;

    assign lost    = rec_in.data[WIDTH-1 -: SHAMT];
    assign shifted = {rec_in.data[WIDTH-SHAMT-1:0], {SHAMT{1'b0}}};
    assign rotated = {rec_in.data[WIDTH-SHAMT-1:0], lost};

    always_comb begin
        rec_out = rec_in;
        if (sel) begin
            if (rec_in.op == SL_ROTATE) begin
                rec_out.data = rotated;
            end else begin
                rec_out.data = shifted;
                rec_out.ovf  = rec_in.ovf | (|lost);
            end
        end
    end

endmodule

// File: rtl/sl_pipe_shifter.sv
// Three-register elastic pipeline around six cascaded shift stages (weights 1..32).
// Handshake on both sides; bubbles collapse and a full pipe still drains and accepts.
module sl_pipe_shifter
    import shifter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    stage_rec_t rec0;
    stage_rec_t st0, st1, st2, st3, st4, st5;
    stage_rec_t r1, r2;
    logic       v1, v2;
    logic       ready1, ready2, ready3;
    logic       unused_bits;

    assign rec0 = '{data: in_data, shamt: in_shamt, op: shift_op_e'(in_op), ovf: 1'b0};

    // Stages 0-1 ahead of R1
    stage_sl #(.SHAMT(1))  u_st0 (.sel(rec0.shamt[0]), .rec_in(rec0), .rec_out(st0));
    stage_sl #(.SHAMT(2))  u_st1 (.sel(st0.shamt[1]),  .rec_in(st0),  .rec_out(st1));

    // Stages 2-3 ahead of R2
    stage_sl #(.SHAMT(4))  u_st2 (.sel(r1.shamt[2]),   .rec_in(r1),   .rec_out(st2));
    stage_sl #(.SHAMT(8))  u_st3 (.sel(st2.shamt[3]),  .rec_in(st2),  .rec_out(st3));

    // Stages 4-5 ahead of R3 (the output register)
    stage_sl #(.SHAMT(16)) u_st4 (.sel(r2.shamt[4]),   .rec_in(r2),   .rec_out(st4));
    stage_sl #(.SHAMT(32)) u_st5 (.sel(st4.shamt[5]),  .rec_in(st4),  .rec_out(st5));

    // Only data and ovf survive into the output register
    assign unused_bits = ^{st5.shamt, st5.op};

    // Elastic ready chain; out_ready reaches in_ready combinationally
    assign ready3   = !out_valid || out_ready;
    assign ready2   = !v2 || ready3;
    assign ready1   = !v1 || ready2;
    assign in_ready = ready1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (ready1) v1 <= in_valid;
            if (ready2) v2 <= v1;
            if (ready3) out_valid <= v2;
            if (v2 && ready3) begin
                out_data <= st5.data;
                out_ovf  <= st5.ovf;
            end
        end
    end

    // Payload registers load on transfer only and need no reset
    always_ff @(posedge clk) begin
        if (in_valid && ready1) r1 <= st1;
        if (v1 && ready2)       r2 <= st3;
    end

endmodule
